// File: rtl/game_pkg.sv
// Shared timing-block definitions: FSM encoding, BCD digit pair, default prescale.
// No latency or backpressure; compile-time constants only.
// Imported by game_countdown_timer and sec_prescaler users.
package game_pkg;

    localparam int DEFAULT_CLK_DIV = 65000000;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_LOADED  = 2'd1;
    localparam logic [1:0] S_RUNNING = 2'd2;
    localparam logic [1:0] S_EXPIRED = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = S_IDLE,
        LOADED  = S_LOADED,
        RUNNING = S_RUNNING,
        EXPIRED = S_EXPIRED
    } timer_state_t;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd_t;

    function automatic bcd_t to_bcd(input logic [6:0] v);
        bcd_t r;
        r.tens = 4'(v / 7'd10);
        r.ones = 4'(v % 7'd10);
        return r;
    endfunction

endpackage

// File: rtl/game_countdown_timer_if.sv
// Phase levels from the game state controller and timer results back to it / the HUD.
// No latency; level signals, no backpressure. pause exists only with TIMER_PAUSE_EN.
// master = controller/HUD side, slave = timer side.
interface game_countdown_timer_if;
    import game_pkg::*;

`ifdef TIMER_PAUSE_EN
    logic pause;
`endif
    logic wait_for_start;
    logic game_on;
    logic time_out;
    logic timer_expired;
    logic sec_tick;
    logic [3:0] secs_tens;
    logic [3:0] secs_ones;
    logic warning;

    modport master (
`ifdef TIMER_PAUSE_EN
        output pause,
`endif
        output wait_for_start,
        output game_on,
        output time_out,
        input  timer_expired,
        input  sec_tick,
        input  secs_tens,
        input  secs_ones,
        input  warning
    );

    modport slave (
`ifdef TIMER_PAUSE_EN
        input  pause,
`endif
        input  wait_for_start,
        input  game_on,
        input  time_out,
        output timer_expired,
        output sec_tick,
        output secs_tens,
        output secs_ones,
        output warning
    );

endinterface

// File: rtl/game_countdown_timer_sec_prescaler.sv
// Divides clk down to a one-per-second strobe; count holds while en=0, clr wins over en.
// tick is combinational: high in the cycle whose edge wraps the count.
// No backpressure.
module sec_prescaler #(
    parameter int CLK_DIV = game_pkg::DEFAULT_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = en && !clr && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/game_countdown_timer.sv
// Round countdown: loads on wait_for_start, counts seconds while playing, raises timer_expired
// one cycle after the final tick edge and holds it. All outputs registered; no backpressure.
// Optional macro TIMER_PAUSE_EN adds bus.pause to freeze the count mid-second.
module game_countdown_timer
    import game_pkg::*;
#(
    parameter int CLK_DIV      = DEFAULT_CLK_DIV,
    parameter int GAME_SECONDS = 60,
    parameter int WARN_SECONDS = 10
) (
    input logic                  clk,
    input logic                  rst,
    game_countdown_timer_if.slave bus
);
    localparam logic [6:0] GAME_L   = 7'(GAME_SECONDS);
    localparam logic [6:0] WARN_L   = 7'(WARN_SECONDS);
    localparam bcd_t       BCD_LOAD = to_bcd(GAME_L);

    timer_state_t state, state_nxt;
    logic [6:0]   remaining, remaining_nxt;
    bcd_t         digits, digits_nxt;
    logic         expired_q, expired_nxt;
    logic         tick_q, tick_nxt;
    logic         warn_q, warn_nxt;
    logic         hold;
    logic         run_en;
    logic         pre_clr;
    logic         pre_tick;

`ifdef TIMER_PAUSE_EN
    assign hold = bus.pause;
`else
    assign hold = 1'b0;
`endif

    // Prescaler is only live in RUNNING, so it restarts from zero on every load.
    assign run_en  = (state == RUNNING) && bus.game_on && !bus.time_out
                     && !bus.wait_for_start && !hold;
    assign pre_clr = bus.wait_for_start || (state != RUNNING);

    sec_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (pre_clr),
        .en   (run_en),
        .tick (pre_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        digits_nxt    = digits;
        expired_nxt   = expired_q;
        tick_nxt      = 1'b0;

        if (bus.wait_for_start) begin
            state_nxt     = LOADED;
            remaining_nxt = GAME_L;
            digits_nxt    = BCD_LOAD;
            expired_nxt   = 1'b0;
        end else if ((state != IDLE) && !bus.game_on) begin
            state_nxt     = IDLE;
            remaining_nxt = GAME_L;
            digits_nxt    = BCD_LOAD;
            expired_nxt   = 1'b0;
        end else begin
            case (state)
                LOADED:  state_nxt = RUNNING;
                RUNNING: begin
                    if (pre_tick && (remaining != 7'd0)) begin
                        tick_nxt      = 1'b1;
                        remaining_nxt = remaining - 7'd1;
                        // Decade borrow keeps the digits in lockstep with the binary count.
                        if (digits.ones == 4'd0) begin
                            digits_nxt.ones = 4'd9;
                            digits_nxt.tens = digits.tens - 4'd1;
                        end else begin
                            digits_nxt.ones = digits.ones - 4'd1;
                        end
                        if (remaining == 7'd1) begin
                            state_nxt = EXPIRED;
                        end
                    end
                end
                EXPIRED: expired_nxt = 1'b1;
                default: ;
            endcase
        end

        warn_nxt = (state_nxt == RUNNING) && (remaining_nxt <= WARN_L)
                   && (remaining_nxt != 7'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remaining <= GAME_L;
            digits    <= BCD_LOAD;
            expired_q <= 1'b0;
            tick_q    <= 1'b0;
            warn_q    <= 1'b0;
        end else begin
            remaining <= remaining_nxt;
            digits    <= digits_nxt;
            expired_q <= expired_nxt;
            tick_q    <= tick_nxt;
            warn_q    <= warn_nxt;
        end
    end

    assign bus.timer_expired = expired_q;
    assign bus.sec_tick      = tick_q;
    assign bus.secs_tens     = digits.tens;
    assign bus.secs_ones     = digits.ones;
    assign bus.warning       = warn_q;

endmodule

// File: tb/tb_game_countdown_timer.sv
// Directed bench: dut_a (CLK_DIV=4, 3 s, warn 1) and dut_b (CLK_DIV=2, 12 s, warn 10).
module tb_game_countdown_timer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    game_countdown_timer_if bus_a();
    game_countdown_timer_if bus_b();

    game_countdown_timer #(.CLK_DIV(4), .GAME_SECONDS(3), .WARN_SECONDS(1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    game_countdown_timer #(.CLK_DIV(2), .GAME_SECONDS(12), .WARN_SECONDS(10)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus_a.wait_for_start = 1'b0; bus_a.game_on = 1'b0; bus_a.time_out = 1'b0;
        bus_b.wait_for_start = 1'b0; bus_b.game_on = 1'b0; bus_b.time_out = 1'b0;
`ifdef TIMER_PAUSE_EN
        bus_a.pause = 1'b0; bus_b.pause = 1'b0;
`endif
        #23;
        rst = 1'b0;
        step();
        checks++;
        if ({bus_a.timer_expired, bus_a.sec_tick, bus_a.warning} !== 3'b000) begin
            failures++;
            $display("FAIL reset_a_flags got=%b want=000",
                     {bus_a.timer_expired, bus_a.sec_tick, bus_a.warning});
        end
        checks++;
        if ({bus_a.secs_tens, bus_a.secs_ones} !== 8'h03) begin
            failures++;
            $display("FAIL reset_a_digits got=%h want=03", {bus_a.secs_tens, bus_a.secs_ones});
        end
        checks++;
        if ({bus_b.secs_tens, bus_b.secs_ones, bus_b.timer_expired, bus_b.warning} !== {8'h12, 2'b00}) begin
            failures++;
            $display("FAIL reset_b got=%h%b%b want=1200",
                     {bus_b.secs_tens, bus_b.secs_ones}, bus_b.timer_expired, bus_b.warning);
        end
    endtask

    task automatic test_countdown();
        int er;
        logic et, ete, ew;
        bus_a.game_on = 1'b1;
        bus_a.wait_for_start = 1'b1;
        step();
        bus_a.wait_for_start = 1'b0;
        step();
        for (int i = 1; i <= 14; i++) begin
            step();
            er  = 3 - i / 4;
            et  = (i % 4 == 0) && (i <= 12);
            ete = (i >= 13);
            ew  = (er == 1);
            checks++;
            if (bus_a.sec_tick !== et) begin
                failures++;
                $display("FAIL cd_tick i=%0d got=%b want=%b", i, bus_a.sec_tick, et);
            end
            checks++;
            if ({bus_a.secs_tens, bus_a.secs_ones} !== {4'(er / 10), 4'(er % 10)}) begin
                failures++;
                $display("FAIL cd_digits i=%0d got=%h want=%0d", i,
                         {bus_a.secs_tens, bus_a.secs_ones}, er);
            end
            checks++;
            if (bus_a.timer_expired !== ete) begin
                failures++;
                $display("FAIL cd_expired i=%0d got=%b want=%b", i, bus_a.timer_expired, ete);
            end
            checks++;
            if (bus_a.warning !== ew) begin
                failures++;
                $display("FAIL cd_warning i=%0d got=%b want=%b", i, bus_a.warning, ew);
            end
        end
    endtask

    task automatic test_restart();
        bus_a.time_out = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({bus_a.timer_expired, bus_a.secs_tens, bus_a.secs_ones} !== {1'b1, 8'h00}) begin
                failures++;
                $display("FAIL hold_expired got=%b%h want=100", bus_a.timer_expired,
                         {bus_a.secs_tens, bus_a.secs_ones});
            end
        end
        bus_a.wait_for_start = 1'b1;
        step();
        checks++;
        if ({bus_a.timer_expired, bus_a.sec_tick, bus_a.secs_tens, bus_a.secs_ones} !== {2'b00, 8'h03}) begin
            failures++;
            $display("FAIL restart_load got=%b%b%h want=0003", bus_a.timer_expired,
                     bus_a.sec_tick, {bus_a.secs_tens, bus_a.secs_ones});
        end
        bus_a.wait_for_start = 1'b0;
        bus_a.time_out = 1'b0;
        step();
        for (int i = 1; i <= 4; i++) begin
            step();
            checks++;
            if (bus_a.sec_tick !== (i == 4)) begin
                failures++;
                $display("FAIL restart_tick i=%0d got=%b want=%b", i, bus_a.sec_tick, (i == 4));
            end
        end
        checks++;
        if ({bus_a.secs_tens, bus_a.secs_ones} !== 8'h02) begin
            failures++;
            $display("FAIL restart_digits got=%h want=02", {bus_a.secs_tens, bus_a.secs_ones});
        end
    endtask

    task automatic test_warning();
        int er;
        logic ew, et;
        bus_b.game_on = 1'b1;
        bus_b.wait_for_start = 1'b1;
        step();
        bus_b.wait_for_start = 1'b0;
        checks++;
        if (bus_b.warning !== 1'b0) begin
            failures++;
            $display("FAIL warn_loaded got=%b want=0", bus_b.warning);
        end
        step();
        for (int i = 1; i <= 25; i++) begin
            step();
            er = 12 - i / 2;
            if (er < 0) er = 0;
            ew = (er <= 10) && (er != 0);
            et = (i % 2 == 0) && (i <= 24);
            checks++;
            if ({bus_b.secs_tens, bus_b.secs_ones} !== {4'(er / 10), 4'(er % 10)}) begin
                failures++;
                $display("FAIL warn_digits i=%0d got=%h want=%0d", i,
                         {bus_b.secs_tens, bus_b.secs_ones}, er);
            end
            checks++;
            if (bus_b.warning !== ew) begin
                failures++;
                $display("FAIL warn_flag rem=%0d got=%b want=%b", er, bus_b.warning, ew);
            end
            checks++;
            if (bus_b.sec_tick !== et) begin
                failures++;
                $display("FAIL warn_tick i=%0d got=%b want=%b", i, bus_b.sec_tick, et);
            end
        end
        checks++;
        if (bus_b.timer_expired !== 1'b1) begin
            failures++;
            $display("FAIL warn_expired got=%b want=1", bus_b.timer_expired);
        end
    endtask

    task automatic test_drop_game_on();
        bus_b.wait_for_start = 1'b1;
        step();
        bus_b.wait_for_start = 1'b0;
        step();
        for (int i = 0; i < 5; i++) step();
        checks++;
        if ({bus_b.secs_tens, bus_b.secs_ones} !== 8'h10) begin
            failures++;
            $display("FAIL drop_pre got=%h want=10", {bus_b.secs_tens, bus_b.secs_ones});
        end
        bus_b.game_on = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if ({bus_b.sec_tick, bus_b.warning, bus_b.timer_expired, bus_b.secs_tens, bus_b.secs_ones}
                !== {3'b000, 8'h12}) begin
                failures++;
                $display("FAIL drop_idle i=%0d got=%b%b%b%h want=00012", i, bus_b.sec_tick,
                         bus_b.warning, bus_b.timer_expired, {bus_b.secs_tens, bus_b.secs_ones});
            end
        end
    endtask

    task automatic test_async_reset();
        bus_a.wait_for_start = 1'b1;
        step();
        bus_a.wait_for_start = 1'b0;
        step();
        for (int i = 0; i < 8; i++) step();
        checks++;
        if ({bus_a.secs_tens, bus_a.secs_ones, bus_a.warning} !== {8'h01, 1'b1}) begin
            failures++;
            $display("FAIL arst_pre got=%h%b want=011", {bus_a.secs_tens, bus_a.secs_ones},
                     bus_a.warning);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus_a.timer_expired, bus_a.sec_tick, bus_a.warning, bus_a.secs_tens, bus_a.secs_ones}
            !== {3'b000, 8'h03}) begin
            failures++;
            $display("FAIL arst_now got=%b%b%b%h want=00003", bus_a.timer_expired,
                     bus_a.sec_tick, bus_a.warning, {bus_a.secs_tens, bus_a.secs_ones});
        end
        #2;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if ({bus_a.timer_expired, bus_a.sec_tick} !== 2'b00) begin
                failures++;
                $display("FAIL arst_after i=%0d got=%b%b want=00", i, bus_a.timer_expired,
                         bus_a.sec_tick);
            end
        end
    endtask

`ifdef TIMER_PAUSE_EN
    task automatic test_pause();
        bus_a.game_on = 1'b1;
        bus_a.wait_for_start = 1'b1;
        step();
        bus_a.wait_for_start = 1'b0;
        step();
        step();
        step();
        bus_a.pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if ({bus_a.sec_tick, bus_a.secs_tens, bus_a.secs_ones} !== {1'b0, 8'h03}) begin
                failures++;
                $display("FAIL pause_hold i=%0d got=%b%h want=003", i, bus_a.sec_tick,
                         {bus_a.secs_tens, bus_a.secs_ones});
            end
        end
        bus_a.pause = 1'b0;
        step();
        checks++;
        if (bus_a.sec_tick !== 1'b0) begin
            failures++;
            $display("FAIL pause_resume1 got=%b want=0", bus_a.sec_tick);
        end
        step();
        checks++;
        if ({bus_a.sec_tick, bus_a.secs_tens, bus_a.secs_ones} !== {1'b1, 8'h02}) begin
            failures++;
            $display("FAIL pause_resume2 got=%b%h want=102", bus_a.sec_tick,
                     {bus_a.secs_tens, bus_a.secs_ones});
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_countdown();
        test_restart();
        test_warning();
        test_drop_game_on();
        test_async_reset();
`ifdef TIMER_PAUSE_EN
        test_pause();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
